// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: entry layout, issued-uop bundle,
// and ROB-relative age helpers used by both the station and its age picker.
package alu_reservation_station_pkg;

  localparam int PREG_W    = 7;
  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 48;
  localparam int RS_DEPTH  = 8;
  localparam int NUM_WB    = 3;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    pr1;
    logic                 rdy1;
    logic [PREG_W-1:0]    pr2;
    logic                 rdy2;
    logic [PREG_W-1:0]    prd;
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

  typedef struct packed {
    logic [PREG_W-1:0]    pr1;
    logic [PREG_W-1:0]    pr2;
    logic [PREG_W-1:0]    prd;
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } issue_uop_t;

  // Distance from the ROB head; smaller is older. Wraps mod 2^TAG_W.
  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                              input logic [TAG_W-1:0] head);
    return tag - head;
  endfunction

  // PR 0 is hardwired ready, so a broadcast of PR 0 never counts as a wakeup.
  function automatic logic wake_hit(input logic [PREG_W-1:0] pr,
                                    input logic [NUM_WB-1:0][PREG_W-1:0] wb_pr,
                                    input logic [NUM_WB-1:0] wb_vld);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++)
      if (wb_vld[k] && (wb_pr[k] == pr) && (pr != '0)) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_age_select.sv
// Oldest-ready picker: one-hot grant of the ready entry with the smallest
// ROB-relative age. Tags of live entries are distinct, so there are no ties.
module rs_age_select
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            rob_head,
  output logic [DEPTH-1:0]            grant,
  output logic                        any
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] best_idx;
  logic [TAG_W-1:0] best_age;
  logic             found;

  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || (rob_age(tags[i], rob_head) < best_age))) begin
        found    = 1'b1;
        best_idx = IDX_W'(i);
        best_age = rob_age(tags[i], rob_head);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[best_idx] = 1'b1;
  end

  assign any = found;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched uops until both sources are ready,
// issues the oldest ready one through a 1-deep issue register, flushes on mispredict.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [PREG_W-1:0]     disp_pr1,
  input  logic [PREG_W-1:0]     disp_pr2,
  input  logic [PREG_W-1:0]     disp_prd,
  input  logic [TAG_W-1:0]      disp_tag,
  input  logic [PAYLOAD_W-1:0]  disp_payload,
  output logic                  alu_rs_check_rdy1,
  output logic                  alu_rs_check_rdy2,
  output logic [PREG_W-1:0]     alu_pr1,
  output logic [PREG_W-1:0]     alu_pr2,
  input  logic                  alu_rs_rdy1,
  input  logic                  alu_rs_rdy2,
  output logic                  alu_set_not_rdy,
  output logic [PREG_W-1:0]     alu_rd,
  input  logic [PREG_W-1:0]     rdy_reg1,
  input  logic [PREG_W-1:0]     rdy_reg2,
  input  logic [PREG_W-1:0]     rdy_reg3,
  input  logic                  reg1_rdy_valid,
  input  logic                  reg2_rdy_valid,
  input  logic                  reg3_rdy_valid,
  input  logic [TAG_W-1:0]      rob_head,
  input  logic                  mispredict,
  input  logic [TAG_W-1:0]      mispredict_tag,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [PREG_W-1:0]     issue_pr1,
  output logic [PREG_W-1:0]     issue_pr2,
  output logic [PREG_W-1:0]     issue_prd,
  output logic [TAG_W-1:0]      issue_tag,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t [DEPTH-1:0]            ent;
  logic [NUM_WB-1:0][PREG_W-1:0]    wb_pr;
  logic [NUM_WB-1:0]                wb_vld;
  logic [DEPTH-1:0]                 rdy_vec;
  logic [DEPTH-1:0][TAG_W-1:0]      tag_vec;
  logic [DEPTH-1:0]                 grant;
  logic                             sel_any;
  issue_uop_t                       sel_uop;
  rs_entry_t                        new_ent;
  logic [IDX_W-1:0]                 free_idx;
  logic [CNT_W-1:0]                 cnt;
  logic [TAG_W-1:0]                 mis_age;
  logic                             disp_fire;
  logic                             load_en;
  logic                             take;

  assign wb_pr  = {rdy_reg3, rdy_reg2, rdy_reg1};
  assign wb_vld = {reg3_rdy_valid, reg2_rdy_valid, reg1_rdy_valid};

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(ent[i].valid);
  end

  assign occupancy  = cnt;
  assign disp_ready = (cnt != CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !mispredict;

  assign alu_rs_check_rdy1 = disp_valid && disp_ready;
  assign alu_rs_check_rdy2 = disp_valid && disp_ready;
  assign alu_pr1           = disp_pr1;
  assign alu_pr2           = disp_pr2;
  assign alu_set_not_rdy   = disp_fire;
  assign alu_rd            = disp_prd;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent[i].valid) free_idx = IDX_W'(i);
  end

  // Same-cycle broadcasts bypass into the new entry so a wakeup is never lost.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.pr1     = disp_pr1;
    new_ent.pr2     = disp_pr2;
    new_ent.rdy1    = alu_rs_rdy1 || (disp_pr1 == '0) || wake_hit(disp_pr1, wb_pr, wb_vld);
    new_ent.rdy2    = alu_rs_rdy2 || (disp_pr2 == '0) || wake_hit(disp_pr2, wb_pr, wb_vld);
    new_ent.prd     = disp_prd;
    new_ent.tag     = disp_tag;
    new_ent.payload = disp_payload;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent[i].valid && ent[i].rdy1 && ent[i].rdy2;
      tag_vec[i] = ent[i].tag;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_sel (
    .ready    (rdy_vec),
    .tags     (tag_vec),
    .rob_head (rob_head),
    .grant    (grant),
    .any      (sel_any)
  );

  always_comb begin
    sel_uop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_uop.pr1     = ent[i].pr1;
        sel_uop.pr2     = ent[i].pr2;
        sel_uop.prd     = ent[i].prd;
        sel_uop.tag     = ent[i].tag;
        sel_uop.payload = ent[i].payload;
      end
    end
  end

  assign mis_age = rob_age(mispredict_tag, rob_head);
  assign load_en = !issue_valid || issue_ready;
  assign take    = load_en && sel_any && !mispredict;

  // Wakeup applies first; flush, issue-free or dispatch-write override it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && wake_hit(ent[i].pr1, wb_pr, wb_vld)) ent[i].rdy1 <= 1'b1;
        if (ent[i].valid && wake_hit(ent[i].pr2, wb_pr, wb_vld)) ent[i].rdy2 <= 1'b1;
        if (mispredict) begin
          if (ent[i].valid && (rob_age(ent[i].tag, rob_head) > mis_age)) ent[i].valid <= 1'b0;
        end else if (take && grant[i]) begin
          ent[i].valid <= 1'b0;
        end else if (disp_fire && (free_idx == IDX_W'(i))) begin
          ent[i] <= new_ent;
        end
      end
    end
  end

  // A held uop the ALU accepts during a mispredict cycle still leaves; nothing new loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_pr1     <= '0;
      issue_pr2     <= '0;
      issue_prd     <= '0;
      issue_tag     <= '0;
      issue_payload <= '0;
    end else if (mispredict) begin
      if (issue_valid && (issue_ready || (rob_age(issue_tag, rob_head) > mis_age)))
        issue_valid <= 1'b0;
    end else if (load_en) begin
      issue_valid <= sel_any;
      if (sel_any) begin
        issue_pr1     <= sel_uop.pr1;
        issue_pr2     <= sel_uop.pr2;
        issue_prd     <= sel_uop.prd;
        issue_tag     <= sel_uop.tag;
        issue_payload <= sel_uop.payload;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized bench: a queue-based reference model predicts every issued uop into a
// scoreboard; a negedge monitor consumes ALU handshakes and checks status outputs.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int DEPTH = RS_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 disp_valid = 1'b0, disp_ready;
  logic [PREG_W-1:0]    disp_pr1 = '0, disp_pr2 = '0, disp_prd = '0;
  logic [TAG_W-1:0]     disp_tag = '0;
  logic [PAYLOAD_W-1:0] disp_payload = '0;
  logic                 alu_rs_check_rdy1, alu_rs_check_rdy2;
  logic [PREG_W-1:0]    alu_pr1, alu_pr2, alu_rd;
  logic                 alu_rs_rdy1 = 1'b0, alu_rs_rdy2 = 1'b0;
  logic                 alu_set_not_rdy;
  logic [PREG_W-1:0]    rdy_reg1 = '0, rdy_reg2 = '0, rdy_reg3 = '0;
  logic                 reg1_rdy_valid = 1'b0, reg2_rdy_valid = 1'b0, reg3_rdy_valid = 1'b0;
  logic [TAG_W-1:0]     rob_head = '0;
  logic                 mispredict = 1'b0;
  logic [TAG_W-1:0]     mispredict_tag = '0;
  logic                 issue_valid, issue_ready = 1'b0;
  logic [PREG_W-1:0]    issue_pr1, issue_pr2, issue_prd;
  logic [TAG_W-1:0]     issue_tag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  alu_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pr1(disp_pr1), .disp_pr2(disp_pr2), .disp_prd(disp_prd),
    .disp_tag(disp_tag), .disp_payload(disp_payload),
    .alu_rs_check_rdy1(alu_rs_check_rdy1), .alu_rs_check_rdy2(alu_rs_check_rdy2),
    .alu_pr1(alu_pr1), .alu_pr2(alu_pr2),
    .alu_rs_rdy1(alu_rs_rdy1), .alu_rs_rdy2(alu_rs_rdy2),
    .alu_set_not_rdy(alu_set_not_rdy), .alu_rd(alu_rd),
    .rdy_reg1(rdy_reg1), .rdy_reg2(rdy_reg2), .rdy_reg3(rdy_reg3),
    .reg1_rdy_valid(reg1_rdy_valid), .reg2_rdy_valid(reg2_rdy_valid),
    .reg3_rdy_valid(reg3_rdy_valid),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pr1(issue_pr1), .issue_pr2(issue_pr2), .issue_prd(issue_prd),
    .issue_tag(issue_tag), .issue_payload(issue_payload),
    .occupancy(occupancy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit [PREG_W-1:0]    pr1, pr2, prd;
    bit                 r1, r2;
    bit [TAG_W-1:0]     tag;
    bit [PAYLOAD_W-1:0] payload;
  } m_uop_t;

  m_uop_t         m_ent[$];
  m_uop_t         exp_q[$];
  m_uop_t         m_is;
  bit             m_iv = 1'b0;
  bit [TAG_W-1:0] next_tag = '0;

  function automatic bit [TAG_W-1:0] agef(input bit [TAG_W-1:0] t, input bit [TAG_W-1:0] h);
    return t - h;
  endfunction

  function automatic bit bcast(input bit [PREG_W-1:0] pr);
    if (pr == 0) return 1'b0;
    return (reg1_rdy_valid && rdy_reg1 == pr) || (reg2_rdy_valid && rdy_reg2 == pr) ||
           (reg3_rdy_valid && rdy_reg3 == pr);
  endfunction

  function automatic void wake_all();
    foreach (m_ent[i]) begin
      if (bcast(m_ent[i].pr1)) m_ent[i].r1 = 1'b1;
      if (bcast(m_ent[i].pr2)) m_ent[i].r2 = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    bit [TAG_W-1:0] ma;
    bit             full;
    int             best;
    m_uop_t         u;
    if (reset) begin
      if (m_iv && !issue_ready) void'(exp_q.pop_back());
      m_ent.delete();
      m_iv     = 1'b0;
      next_tag = '0;
    end else if (mispredict) begin
      ma = agef(mispredict_tag, rob_head);
      for (int i = m_ent.size() - 1; i >= 0; i--)
        if (agef(m_ent[i].tag, rob_head) > ma) m_ent.delete(i);
      wake_all();
      if (m_iv && (issue_ready || agef(m_is.tag, rob_head) > ma)) begin
        if (!issue_ready) void'(exp_q.pop_back());
        m_iv = 1'b0;
      end
      next_tag = mispredict_tag + 1'b1;
    end else begin
      full = (m_ent.size() >= DEPTH);
      if (!m_iv || issue_ready) begin
        best = -1;
        foreach (m_ent[i])
          if (m_ent[i].r1 && m_ent[i].r2 &&
              (best < 0 || agef(m_ent[i].tag, rob_head) < agef(m_ent[best].tag, rob_head)))
            best = i;
        if (best >= 0) begin
          m_is = m_ent[best];
          m_iv = 1'b1;
          exp_q.push_back(m_is);
          m_ent.delete(best);
        end else begin
          m_iv = 1'b0;
        end
      end
      wake_all();
      if (disp_valid && !full) begin
        u.pr1 = disp_pr1; u.pr2 = disp_pr2; u.prd = disp_prd;
        u.tag = disp_tag; u.payload = disp_payload;
        u.r1  = alu_rs_rdy1 || disp_pr1 == 0 || bcast(disp_pr1);
        u.r2  = alu_rs_rdy2 || disp_pr2 == 0 || bcast(disp_pr2);
        m_ent.push_back(u);
        next_tag = next_tag + 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0, errors = 0, rd_idx = 0;
  bit mon_en = 1'b0, chk_zero = 1'b0, do_final = 1'b0, final_done = 1'b0, drain_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    m_uop_t e;
    if (mon_en) begin
      chk("occupancy", 64'(occupancy), 64'(m_ent.size()));
      chk("disp_ready", 64'(disp_ready), 64'(m_ent.size() < DEPTH));
      chk("issue_valid", 64'(issue_valid), 64'(m_iv));
      chk("set_not_rdy", 64'(alu_set_not_rdy), 64'(disp_valid && m_ent.size() < DEPTH && !mispredict));
      chk("check_rdy", 64'({alu_rs_check_rdy1, alu_rs_check_rdy2}),
          64'({2{disp_valid && m_ent.size() < DEPTH}}));
      chk("alu_regs", 64'({alu_pr1, alu_pr2, alu_rd}), 64'({disp_pr1, disp_pr2, disp_prd}));
      if (issue_valid && issue_ready) begin
        if (rd_idx >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got tag %0h expected no issue at %0t", issue_tag, $time);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          chk("issue_tag", 64'(issue_tag), 64'(e.tag));
          chk("issue_prs", 64'({issue_pr1, issue_pr2, issue_prd}), 64'({e.pr1, e.pr2, e.prd}));
          chk("issue_payload", 64'(issue_payload), 64'(e.payload));
        end
      end
      if (chk_zero) begin
        chk("rst_fields", 64'({issue_pr1, issue_pr2, issue_prd, issue_tag}), 64'(0));
        chk("rst_payload", 64'(issue_payload), 64'(0));
      end
      if (do_final && !final_done) begin
        chk("drain_done", 64'(drain_ok), 64'(1));
        chk("all_issued", 64'(rd_idx), 64'(exp_q.size()));
        final_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input int p_disp, input int p_rdy, input int p_iss,
                     input int p_mis, input int p_wake);
    bit [TAG_W-1:0] lt[$];
    bit [TAG_W-1:0] rh;
    @(posedge clk); #1;
    reset = rst;
    foreach (m_ent[i]) lt.push_back(m_ent[i].tag);
    if (m_iv) lt.push_back(m_is.tag);
    rh = next_tag;
    if (lt.size() > 0) begin
      rh = lt[0];
      foreach (lt[i]) if (agef(lt[i], rob_head) < agef(rh, rob_head)) rh = lt[i];
    end
    rob_head       = rh;
    mispredict     = (lt.size() > 0) && ($urandom_range(99) < p_mis);
    mispredict_tag = mispredict ? lt[$urandom_range(lt.size() - 1)] : '0;
    disp_valid     = ($urandom_range(99) < p_disp) && (agef(next_tag, rh) < 13);
    disp_tag       = next_tag;
    disp_pr1       = PREG_W'($urandom_range(15));
    disp_pr2       = PREG_W'($urandom_range(15));
    disp_prd       = PREG_W'($urandom_range(127));
    disp_payload[47:32] = 16'($urandom);
    disp_payload[31:0]  = $urandom;
    alu_rs_rdy1    = $urandom_range(99) < p_rdy;
    alu_rs_rdy2    = $urandom_range(99) < p_rdy;
    rdy_reg1       = PREG_W'($urandom_range(15));
    rdy_reg2       = PREG_W'($urandom_range(15));
    rdy_reg3       = PREG_W'($urandom_range(15));
    reg1_rdy_valid = $urandom_range(99) < p_wake;
    reg2_rdy_valid = $urandom_range(99) < p_wake;
    reg3_rdy_valid = $urandom_range(99) < p_wake;
    issue_ready    = $urandom_range(99) < p_iss;
  endtask

  initial begin
    @(posedge clk); #1;
    mon_en   = 1'b1;
    chk_zero = 1'b1;
    @(negedge clk); #1;
    chk_zero = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    // fill until full with mostly unready sources and a stalled ALU
    repeat (40) cyc(0, 90, 10, 5, 0, 2);
    // release: wakeups and issue while still dispatching
    repeat (40) cyc(0, 70, 20, 80, 0, 30);
    repeat (1500) cyc(0, 60, 50, 70, 3, 30);
    // heavy mispredict traffic with back-pressure
    repeat (400) cyc(0, 80, 40, 40, 10, 20);
    cyc(1, 60, 50, 70, 0, 30);
    repeat (300) cyc(0, 60, 50, 70, 3, 30);
    for (int n = 0; n < 400 && !(m_ent.size() == 0 && !m_iv); n++) cyc(0, 0, 0, 100, 0, 100);
    drain_ok = (m_ent.size() == 0) && !m_iv;
    cyc(0, 0, 0, 100, 0, 0);
    do_final = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
